// File: rtl/sfp_ctrl_if.sv
// Signal bundle between an SFP cage supervisor and its surroundings:
// cage pins (detect/los/fault/shutdown) plus enable request and status.
interface sfp_ctrl_if;
  logic       enable;
  logic       detect;
  logic       los;
  logic       fault;
  logic       shutdown;
  logic       present;
  logic       link_up;
  logic       fault_flag;
  logic [2:0] retry_cnt;
  logic [2:0] state;

  modport slave (
    input  enable, detect, los, fault,
    output shutdown, present, link_up, fault_flag, retry_cnt, state
  );

  modport master (
    output enable, detect, los, fault,
    input  shutdown, present, link_up, fault_flag, retry_cnt, state
  );
endinterface

// File: rtl/sfp_ctrl.sv
// SFP cage supervisor: presence debounce, TX_DISABLE sequencing,
// TX_FAULT recovery with bounded retries, and LOS qualification of link_up.
module sfp_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int T_INIT_CYC   = 30_000_000,
  parameter int T_RESET_CYC  = 1_000,
  parameter int LOS_FILT_CYC = 1_000,
  parameter int MAX_RETRY    = 3
) (
  input logic      clk,
  input logic      rst,
  sfp_ctrl_if.slave bus
);

  // state   | meaning
  // ABSENT  | no module seated, transmitter off
  // IDLE    | module present, waiting for enable
  // INIT    | transmitter on, fault masked during t_init
  // ACTIVE  | running, fault honoured, los qualified
  // FLT_RST | disable pulse to clear a transmitter fault
  // LOCKOUT | retries exhausted, held off until enable drops
  typedef enum logic [2:0] {
    ABSENT  = 3'd0,
    IDLE    = 3'd1,
    INIT    = 3'd2,
    ACTIVE  = 3'd3,
    FLT_RST = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  localparam int M_A  = (DEBOUNCE_CYC > T_INIT_CYC)  ? DEBOUNCE_CYC : T_INIT_CYC;
  localparam int M_B  = (T_RESET_CYC  > LOS_FILT_CYC) ? T_RESET_CYC  : LOS_FILT_CYC;
  localparam int MAXP = (M_A > M_B) ? M_A : M_B;
  localparam int TW   = $clog2(MAXP) + 1;

  localparam logic [TW-1:0] ONE     = TW'(1);
  localparam logic [TW-1:0] DEB_TC  = TW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] INIT_TC = TW'(T_INIT_CYC - 1);
  localparam logic [TW-1:0] RST_TC  = TW'(T_RESET_CYC - 1);
  localparam logic [TW-1:0] LOS_SAT = TW'(LOS_FILT_CYC);
  localparam logic [2:0]    RET_MAX = 3'(MAX_RETRY);

  logic det_s1_q, det_s_q, los_s1_q, los_s_q, flt_s1_q, flt_s_q;

  logic [TW-1:0] deb_cnt_q, deb_cnt_d;
  logic          present_q, present_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    retry_q, retry_d;
  logic          flag_q, flag_d;
  logic          shutdown_q, shutdown_d;
  logic [TW-1:0] los_cnt_q, los_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      det_s1_q   <= 1'b1;
      det_s_q    <= 1'b1;
      los_s1_q   <= 1'b1;
      los_s_q    <= 1'b1;
      flt_s1_q   <= 1'b0;
      flt_s_q    <= 1'b0;
      deb_cnt_q  <= DEB_TC;
      present_q  <= 1'b0;
      state_q    <= ABSENT;
      timer_q    <= '0;
      retry_q    <= '0;
      flag_q     <= 1'b0;
      shutdown_q <= 1'b1;
      los_cnt_q  <= '0;
    end else begin
      det_s1_q   <= bus.detect;
      det_s_q    <= det_s1_q;
      los_s1_q   <= bus.los;
      los_s_q    <= los_s1_q;
      flt_s1_q   <= bus.fault;
      flt_s_q    <= flt_s1_q;
      deb_cnt_q  <= deb_cnt_d;
      present_q  <= present_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      flag_q     <= flag_d;
      shutdown_q <= shutdown_d;
      los_cnt_q  <= los_cnt_d;
    end
  end

  // A pending edge in the synchronizer reloads the window, so present only
  // follows once the synced pin has held still for the full debounce time.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    present_d = present_q;
    if (det_s1_q != det_s_q)
      deb_cnt_d = DEB_TC;
    else if (deb_cnt_q != '0)
      deb_cnt_d = deb_cnt_q - ONE;
    else
      present_d = ~det_s_q;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    flag_d  = flag_q;
    if (!bus.enable)
      flag_d = 1'b0;
    if (!present_q) begin
      state_d = ABSENT;
      timer_d = '0;
      retry_d = '0;
    end else if (!bus.enable && state_q != ABSENT && state_q != IDLE) begin
      state_d = IDLE;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ABSENT: state_d = IDLE;
        IDLE: begin
          if (bus.enable) begin
            state_d = INIT;
            timer_d = '0;
          end
        end
        INIT: begin
          if (timer_q == INIT_TC) begin
            state_d = ACTIVE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        ACTIVE: begin
          // In ACTIVE the timer measures fault-free run time for retry forgiveness.
          if (flt_s_q) begin
            flag_d  = 1'b1;
            timer_d = '0;
            if (retry_q < RET_MAX) begin
              state_d = FLT_RST;
              retry_d = retry_q + 3'd1;
            end else begin
              state_d = LOCKOUT;
            end
          end else if (timer_q == INIT_TC) begin
            retry_d = '0;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        FLT_RST: begin
          if (timer_q == RST_TC) begin
            state_d = INIT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        LOCKOUT: state_d = LOCKOUT;
        default: state_d = ABSENT;
      endcase
    end
  end

  // Driven from the next state so shutdown moves on the same edge as the state
  // register and can never dip low while entering or sitting in an off state.
  always_comb begin
    shutdown_d = !(state_d == INIT || state_d == ACTIVE);
    los_cnt_d  = '0;
    if (state_q == ACTIVE && !los_s_q)
      los_cnt_d = (los_cnt_q == LOS_SAT) ? los_cnt_q : los_cnt_q + ONE;
  end

  assign bus.shutdown   = shutdown_q;
  assign bus.present    = present_q;
  assign bus.link_up    = (los_cnt_q == LOS_SAT);
  assign bus.fault_flag = flag_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl with randomized timing; expected cycle positions
// come from arithmetic on the configured debounce/init/reset/filter windows.
module tb_sfp_ctrl;
  localparam int D  = 8;
  localparam int TI = 20;
  localparam int TR = 4;
  localparam int LF = 5;
  localparam int MR = 2;

  localparam logic [2:0] S_ABSENT  = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_INIT    = 3'd2;
  localparam logic [2:0] S_ACTIVE  = 3'd3;
  localparam logic [2:0] S_FLT_RST = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  // Synchronizer (2) + debounce window: cycles from pin change to present update.
  localparam int PRES_LAT = D + 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  sfp_ctrl_if sif();

  sfp_ctrl #(
    .DEBOUNCE_CYC (D),
    .T_INIT_CYC   (TI),
    .T_RESET_CYC  (TR),
    .LOS_FILT_CYC (LF),
    .MAX_RETRY    (MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (sif.state !== s && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, {29'd0, sif.state}, {29'd0, s});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_shutdown"},   {31'd0, sif.shutdown},   32'd1);
    chk({tag, "_present"},    {31'd0, sif.present},    32'd0);
    chk({tag, "_link_up"},    {31'd0, sif.link_up},    32'd0);
    chk({tag, "_fault_flag"}, {31'd0, sif.fault_flag}, 32'd0);
    chk({tag, "_retry"},      {29'd0, sif.retry_cnt},  32'd0);
    chk({tag, "_state"},      {29'd0, sif.state},      {29'd0, S_ABSENT});
  endtask

  task automatic chk_st(input string tag, input logic [2:0] s);
    chk(tag, {29'd0, sif.state}, {29'd0, s});
  endtask

  // Counts consecutive samples with shutdown high, starting from the current one.
  task automatic shutdown_pulse(input string tag, input int expected);
    int hi = 0;
    while (sif.shutdown === 1'b1 && hi < 50) begin
      hi++;
      step(1);
    end
    chk(tag, hi, expected);
  endtask

  initial begin
    int w1, w2, w3, k;
    rst = 1'b1;
    sif.enable = 1'b0;
    sif.detect = 1'b1;
    sif.los    = 1'b1;
    sif.fault  = 1'b0;
    step(2);
    chk_reset("reset");

    rst = 1'b0;
    sif.enable = 1'b1;
    step(3);
    chk_st("absent_hold", S_ABSENT);

    // 1: insertion with bounce, then power-up sequence
    w1 = $urandom_range(1, 3);
    w2 = $urandom_range(1, 3);
    sif.detect = 1'b0; step(w1);
    sif.detect = 1'b1; step(w2);
    sif.detect = 1'b0;
    step(PRES_LAT - 1);
    chk("present_early", {31'd0, sif.present}, 32'd0);
    step(1);
    chk("present_rise", {31'd0, sif.present}, 32'd1);
    step(1);
    chk_st("idle", S_IDLE);
    chk("idle_shutdown", {31'd0, sif.shutdown}, 32'd1);
    step(1);
    chk_st("init", S_INIT);
    chk("init_shutdown", {31'd0, sif.shutdown}, 32'd0);
    step(TI - 1);
    chk_st("init_last", S_INIT);
    step(1);
    chk_st("active", S_ACTIVE);

    // 2: LOS filter
    step($urandom_range(0, 5));
    sif.los = 1'b0;
    step(2 + LF - 1);
    chk("link_early", {31'd0, sif.link_up}, 32'd0);
    step(1);
    chk("link_rise", {31'd0, sif.link_up}, 32'd1);
    step($urandom_range(1, 6));
    sif.los = 1'b1; step(1);
    sif.los = 1'b0; step(1);
    chk("link_hold_sync", {31'd0, sif.link_up}, 32'd1);
    step(1);
    chk("link_drop", {31'd0, sif.link_up}, 32'd0);
    step(LF - 1);
    chk("link_recount", {31'd0, sif.link_up}, 32'd0);
    step(1);
    chk("link_rerise", {31'd0, sif.link_up}, 32'd1);

    // 3: persistent fault -> MR recovery pulses then lockout
    step($urandom_range(0, 4));
    sif.fault = 1'b1;
    step(3);
    chk_st("flt1", S_FLT_RST);
    chk("flt1_retry", {29'd0, sif.retry_cnt}, 32'd1);
    chk("flt1_flag", {31'd0, sif.fault_flag}, 32'd1);
    shutdown_pulse("flt1_pulse", TR);
    chk_st("flt1_init", S_INIT);
    step(TI);
    chk_st("flt2_active", S_ACTIVE);
    step(1);
    chk_st("flt2", S_FLT_RST);
    chk("flt2_retry", {29'd0, sif.retry_cnt}, 32'd2);
    shutdown_pulse("flt2_pulse", TR);
    step(TI);
    chk_st("flt3_active", S_ACTIVE);
    step(1);
    chk_st("lockout", S_LOCKOUT);
    chk("lockout_shutdown", {31'd0, sif.shutdown}, 32'd1);
    chk("lockout_retry", {29'd0, sif.retry_cnt}, MR);
    sif.fault = 1'b0;
    step($urandom_range(3, 10));
    chk_st("lockout_hold", S_LOCKOUT);
    sif.enable = 1'b0;
    step(1);
    chk_st("dis_idle", S_IDLE);
    chk("dis_retry", {29'd0, sif.retry_cnt}, 32'd0);
    chk("dis_flag", {31'd0, sif.fault_flag}, 32'd0);

    // 4: fault masked in INIT, honoured on ACTIVE entry; retry forgiveness
    sif.enable = 1'b1;
    step(1);
    chk_st("t4_init", S_INIT);
    k = $urandom_range(0, 15);
    step(k);
    sif.fault = 1'b1;
    step(TI - 1 - k);
    chk_st("t4_masked", S_INIT);
    step(1);
    chk_st("t4_active", S_ACTIVE);
    step(1);
    chk_st("t4_flt", S_FLT_RST);
    chk("t4_retry", {29'd0, sif.retry_cnt}, 32'd1);
    sif.fault = 1'b0;
    wait_state("t4_reactive", S_ACTIVE, TR + TI + 5);
    chk("t4_retry_kept", {29'd0, sif.retry_cnt}, 32'd1);
    step(TI - 1);
    chk("t4_retry_pre", {29'd0, sif.retry_cnt}, 32'd1);
    step(1);
    chk("t4_retry_clr", {29'd0, sif.retry_cnt}, 32'd0);

    // 5: removal in ACTIVE
    step(LF + 2);
    chk("t5_link", {31'd0, sif.link_up}, 32'd1);
    sif.detect = 1'b1;
    step(PRES_LAT - 1);
    chk("t5_present_hold", {31'd0, sif.present}, 32'd1);
    step(1);
    chk("t5_present_fall", {31'd0, sif.present}, 32'd0);
    step(1);
    chk_st("t5_absent", S_ABSENT);
    chk("t5_shutdown", {31'd0, sif.shutdown}, 32'd1);
    chk("t5_retry", {29'd0, sif.retry_cnt}, 32'd0);
    step(1);
    chk("t5_link_drop", {31'd0, sif.link_up}, 32'd0);

    // 6: reset during FLT_RST and during ACTIVE
    sif.detect = 1'b0;
    wait_state("t6_active1", S_ACTIVE, PRES_LAT + TI + 10);
    sif.fault = 1'b1;
    step(3);
    chk_st("t6_flt", S_FLT_RST);
    rst = 1'b1;
    sif.fault = 1'b0;
    step(1);
    chk_reset("t6_rst_flt");
    rst = 1'b0;
    for (int i = 0; i < PRES_LAT; i++) begin
      chk("t6_no_low_pulse", {31'd0, sif.shutdown}, 32'd1);
      step(1);
    end
    wait_state("t6_active2", S_ACTIVE, PRES_LAT + TI + 10);
    step($urandom_range(0, 8));
    rst = 1'b1;
    step(1);
    chk_reset("t6_rst_active");
    rst = 1'b0;
    step(1);
    chk("t6_post_shutdown", {31'd0, sif.shutdown}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
